// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32 pipeline.
// Load-use, taken-branch and data-memory-wait handling, with a wait watchdog and perf counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERROR} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WCNT_W-1:0] r_wcnt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic              w_lu;
  logic              w_mem_block;
  logic              w_branch_act;

  assign w_lu = ex_mem_read && (ex_rd != 5'd0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  // In WAIT the stall holds on mem_ready alone; in RUN it needs an outstanding request.
  assign w_mem_block = (r_state == S_WAIT) ? !mem_ready
                                           : ((r_state == S_RUN) && mem_req && !mem_ready);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RUN:   if (mem_req && !mem_ready) w_next = S_WAIT;
      S_WAIT: begin
        if (mem_ready)                w_next = S_RUN;
        else if (r_wcnt == WCNT_LAST) w_next = S_ERROR;
      end
      default: w_next = S_ERROR;
    endcase
  end

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    w_branch_act = 1'b0;
    if (reset) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
      {if_id_flush, id_ex_flush, mem_wb_flush}          = '1;
    end else if (r_state == S_ERROR) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
    end else if (w_mem_block) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en} = '0;
      mem_wb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      w_branch_act = 1'b1;
    end else if (w_lu) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  assign mem_timeout = (r_state == S_ERROR);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wcnt <= '0;
    end else if ((r_state == S_WAIT) && !mem_ready && (w_next == S_WAIT)) begin
      r_wcnt <= r_wcnt + WCNT_W'(1);
    end else begin
      r_wcnt <= '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_en)       r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_branch_act) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;

endmodule
